reg_file: RTL and testbench

Architectural register file with rename tags. It sits directly downstream of the reorder buffer, which writes committed register results and frees tags through it. Decode reads source values and dependency tags here, and records the destination tag (ROB index) of each newly dispatched instruction. On flush it drops all outstanding tags so every register reads as architecturally resolved.

---
 rtl/reg_file.sv | 122 ++++++++++++
 tb/tb_reg_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with rename tags. The ROB commits values and
// releases tags; decode reads operands/tags and records new destination tags.
module reg_file #(
    parameter int unsigned REG_NUM_WIDTH  = 5,
    parameter int unsigned ROB_SIZE_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      rob_valid,
    input  logic [REG_NUM_WIDTH-1:0]  rob_rd,
    input  logic [31:0]               rob_value,
    input  logic [ROB_SIZE_WIDTH:0]   rob_dependency,
    input  logic                      dec_valid,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id,
    input  logic [REG_NUM_WIDTH-1:0]  rs1_in,
    input  logic [REG_NUM_WIDTH-1:0]  rs2_in,
    output logic [31:0]               value1_out,
    output logic [ROB_SIZE_WIDTH:0]   dependency1_out,
    output logic [31:0]               value2_out,
    output logic [ROB_SIZE_WIDTH:0]   dependency2_out,
    output logic [REG_NUM_WIDTH:0]    pending_cnt_out
);

    localparam int unsigned NumRegs = 1 << REG_NUM_WIDTH;
    localparam int unsigned TagW    = ROB_SIZE_WIDTH + 1;
    localparam int unsigned CntW    = REG_NUM_WIDTH + 1;

    localparam logic [TagW-1:0] TagNone = '1;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntMax  = CntW'(NumRegs - 1);

    logic [31:0]     value_q [NumRegs];
    logic [31:0]     value_d [NumRegs];
    logic [TagW-1:0] tag_q   [NumRegs];
    logic [TagW-1:0] tag_d   [NumRegs];
    logic [CntW-1:0] pending_q, pending_d;
    logic [CntW-1:0] cnt;

    // Next-state: commit first, then flush or rename overrides the tag.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (rdy_in) begin
            if (rob_valid && (rob_rd != '0)) begin
                value_d[rob_rd] = rob_value;
                // Only release the tag if no younger rename has replaced it.
                if (tag_q[rob_rd] == rob_dependency) begin
                    tag_d[rob_rd] = TagNone;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < NumRegs; i++) begin
                    tag_d[i] = TagNone;
                end
            end else if (dec_valid && (dec_rd != '0)) begin
                tag_d[dec_rd] = {1'b0, dec_rob_id};
            end
        end
    end

    // Saturating count of outstanding tags in the next-state array.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if ((tag_d[i] != TagNone) && (cnt != CntMax)) begin
                cnt = cnt + CntOne;
            end
        end
        pending_d = rdy_in ? cnt : pending_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NumRegs; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= TagNone;
            end
            pending_q <= '0;
        end else begin
            value_q   <= value_d;
            tag_q     <= tag_d;
            pending_q <= pending_d;
        end
    end

    // Read port 1 with same-cycle commit bypass (no rename bypass).
    always_comb begin
        value1_out      = value_q[rs1_in];
        dependency1_out = tag_q[rs1_in];
        if (rs1_in == '0) begin
            value1_out      = '0;
            dependency1_out = TagNone;
        end else if (rdy_in && rob_valid && (rob_rd == rs1_in)) begin
            value1_out = rob_value;
            if (tag_q[rs1_in] == rob_dependency) begin
                dependency1_out = TagNone;
            end
        end
    end

    // Read port 2 with same-cycle commit bypass (no rename bypass).
    always_comb begin
        value2_out      = value_q[rs2_in];
        dependency2_out = tag_q[rs2_in];
        if (rs2_in == '0) begin
            value2_out      = '0;
            dependency2_out = TagNone;
        end else if (rdy_in && rob_valid && (rob_rd == rs2_in)) begin
            value2_out = rob_value;
            if (tag_q[rs2_in] == rob_dependency) begin
                dependency2_out = TagNone;
            end
        end
    end

    assign pending_cnt_out = pending_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all checked against an array-based reference model.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in, flush_in;
    logic        rob_valid;
    logic [4:0]  rob_rd;
    logic [31:0] rob_value;
    logic [5:0]  rob_dependency;
    logic        dec_valid;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rob_id;
    logic [4:0]  rs1_in, rs2_in;
    logic [31:0] value1_out, value2_out;
    logic [5:0]  dependency1_out, dependency2_out;
    logic [5:0]  pending_cnt_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: m_tag = -1 means no outstanding rename.
    int          m_tag [32];
    logic [31:0] m_val [32];

    always #5 clk_in = ~clk_in;

    reg_file #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .rob_valid       (rob_valid),
        .rob_rd          (rob_rd),
        .rob_value       (rob_value),
        .rob_dependency  (rob_dependency),
        .dec_valid       (dec_valid),
        .dec_rd          (dec_rd),
        .dec_rob_id      (dec_rob_id),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .value1_out      (value1_out),
        .dependency1_out (dependency1_out),
        .value2_out      (value2_out),
        .dependency2_out (dependency2_out),
        .pending_cnt_out (pending_cnt_out)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [5:0] tag6(input int t);
        return (t < 0) ? 6'h3F : 6'(t);
    endfunction

    function automatic logic [31:0] exp_val(input int rs);
        if (rs == 0) return 32'h0;
        if (rdy_in && rob_valid && int'(rob_rd) == rs) return rob_value;
        return m_val[rs];
    endfunction

    function automatic logic [5:0] exp_dep(input int rs);
        if (rs == 0) return 6'h3F;
        if (rdy_in && rob_valid && int'(rob_rd) == rs && tag6(m_tag[rs]) == rob_dependency)
            return 6'h3F;
        return tag6(m_tag[rs]);
    endfunction

    function automatic logic [31:0] exp_pending();
        int c = 0;
        for (int i = 1; i < 32; i++) if (m_tag[i] >= 0) c++;
        return (c > 31) ? 32'd31 : 32'(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_tag[i] = -1;
            m_val[i] = 32'h0;
        end
    endtask

    // Apply inputs, then check combinational reads against the model.
    task automatic drive(input bit rdy, input bit fl, input bit rv, input int rrd,
                         input logic [31:0] rval, input int rdep, input bit dv,
                         input int drd, input int did, input int r1, input int r2);
        rdy_in = rdy; flush_in = fl; rob_valid = rv; rob_rd = 5'(rrd);
        rob_value = rval; rob_dependency = 6'(rdep); dec_valid = dv;
        dec_rd = 5'(drd); dec_rob_id = 5'(did); rs1_in = 5'(r1); rs2_in = 5'(r2);
        #1;
        check("rd1_value", value1_out, exp_val(r1));
        check("rd1_dep", 32'(dependency1_out), 32'(exp_dep(r1)));
        check("rd2_value", value2_out, exp_val(r2));
        check("rd2_dep", 32'(dependency2_out), 32'(exp_dep(r2)));
    endtask

    // Clock edge, advance the model by the architectural rules, check count.
    task automatic cycle();
        @(posedge clk_in);
        #1;
        if (rdy_in) begin
            if (rob_valid && rob_rd != 0) begin
                m_val[rob_rd] = rob_value;
                if (tag6(m_tag[rob_rd]) == rob_dependency) m_tag[rob_rd] = -1;
            end
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_tag[i] = -1;
            end else if (dec_valid && dec_rd != 0) begin
                m_tag[dec_rd] = int'(dec_rob_id);
            end
        end
        check("pending", 32'(pending_cnt_out), exp_pending());
    endtask

    task automatic idle_read(input int r1, input int r2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        rst_in = 1'b0;
        model_reset();
        rdy_in = 0; flush_in = 0; rob_valid = 0; rob_rd = 0; rob_value = 0;
        rob_dependency = 0; dec_valid = 0; dec_rd = 0; dec_rob_id = 0;
        rs1_in = 5'd5; rs2_in = 5'd0;
        #12;
        rst_in = 1'b1;

        // Reset state.
        idle_read(5, 0);
        check("reset_x5_value", value1_out, 32'h0);
        check("reset_x5_dep", 32'(dependency1_out), 32'h3F);
        check("reset_pending", 32'(pending_cnt_out), 32'h0);
        cycle();

        // Rename then commit with bypass.
        drive(1, 0, 0, 0, 0, 0, 1, 5, 3, 5, 5);
        cycle();
        check("x5_tag", 32'(dependency1_out), 32'h3);
        drive(1, 0, 1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 5, 6);
        check("bypass_value", value1_out, 32'hDEADBEEF);
        check("bypass_dep", 32'(dependency1_out), 32'h3F);
        cycle();
        idle_read(5, 0);
        check("x5_committed", value1_out, 32'hDEADBEEF);
        check("x5_resolved", 32'(dependency1_out), 32'h3F);
        check("pending_zero", 32'(pending_cnt_out), 32'h0);
        cycle();

        // Stale commit keeps newer rename.
        drive(1, 0, 0, 0, 0, 0, 1, 7, 2, 7, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 9, 7, 0);
        cycle();
        drive(1, 0, 1, 7, 32'h11, 2, 0, 0, 0, 7, 0);
        check("stale_bypass_dep", 32'(dependency1_out), 32'h9);
        cycle();
        idle_read(7, 0);
        check("x7_value", value1_out, 32'h11);
        check("x7_tag", 32'(dependency1_out), 32'h9);
        check("pending_one", 32'(pending_cnt_out), 32'h1);
        cycle();

        // Same-cycle commit and rename: rename wins the tag.
        drive(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        cycle();
        drive(1, 0, 1, 4, 32'h22, 1, 1, 4, 6, 4, 0);
        cycle();
        idle_read(4, 0);
        check("x4_value", value1_out, 32'h22);
        check("x4_tag", 32'(dependency1_out), 32'h6);
        cycle();

        // Flush with concurrent commit and ignored rename.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 1, 1, 2);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 1, 3, 2, 2, 3);
        cycle();
        check("pending_three", 32'(pending_cnt_out), 32'h3);
        drive(1, 1, 1, 1, 32'h40, 0, 1, 8, 4, 1, 8);
        cycle();
        idle_read(1, 8);
        check("flush_x1_value", value1_out, 32'h40);
        check("flush_x1_dep", 32'(dependency1_out), 32'h3F);
        check("flush_x8_dep", 32'(dependency2_out), 32'h3F);
        check("flush_pending", 32'(pending_cnt_out), 32'h0);
        cycle();

        // x0 ignores writes and renames.
        drive(1, 0, 1, 0, 32'h55, 0, 1, 0, 4, 0, 0);
        cycle();
        idle_read(0, 0);
        check("x0_value", value1_out, 32'h0);
        check("x0_dep", 32'(dependency1_out), 32'h3F);
        cycle();

        // rdy low: no bypass, no state change.
        drive(0, 0, 1, 9, 32'h99, 63, 1, 9, 5, 9, 0);
        check("hold_nobypass", value1_out, 32'h0);
        cycle();
        idle_read(9, 0);
        check("hold_x9_value", value1_out, 32'h0);
        check("hold_x9_dep", 32'(dependency1_out), 32'h3F);
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            int rrd, rdep, drd, r1, r2;
            rrd = $urandom_range(0, 31);
            rdep = ($urandom_range(0, 3) != 0) ? int'(tag6(m_tag[rrd])) : $urandom_range(0, 63);
            drd = $urandom_range(0, 31);
            r1 = ($urandom_range(0, 2) == 0) ? rrd : $urandom_range(0, 31);
            r2 = ($urandom_range(0, 2) == 0) ? drd : $urandom_range(0, 31);
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 1) == 1), rrd, $urandom, rdep,
                  ($urandom_range(0, 3) != 0), drd, $urandom_range(0, 31), r1, r2);
            cycle();
        end

        // Asynchronous reset mid-operation.
        drive(1, 0, 0, 0, 0, 0, 1, 12, 7, 1, 12);
        cycle();
        idle_read(1, 12);
        #1 rst_in = 1'b0;
        #1;
        model_reset();
        check("async_x1_value", value1_out, 32'h0);
        check("async_x12_dep", 32'(dependency2_out), 32'h3F);
        check("async_pending", 32'(pending_cnt_out), 32'h0);
        rst_in = 1'b1;
        cycle();
        idle_read(1, 12);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
